// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sharing one adder among NREQ requesters
module adder_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    aclk,
    input  logic                    arstn,
    input  logic                    srst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_c,
    output logic [IDW-1:0]          rsp_id,
    output logic                    busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_RESP} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   id_q;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   cand;
    logic             grant_found;
    logic             capture;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum;

    // Rotating-priority search: first requester at or after ptr, wrapping.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign capture = (state_q == ST_IDLE) && grant_found && !srst;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= ST_IDLE;
        end else if (srst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (capture) state_d = (LATENCY == 0) ? ST_RESP : ST_EXEC;
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (capture) req_ready[grant_idx] = 1'b1;
        rsp_valid = (state_q == ST_RESP);
        busy      = (state_q != ST_IDLE);
    end

    // Operand registers feed the adder and hold until the response is taken.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ptr_q  <= '0;
            id_q   <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (srst) begin
            ptr_q  <= '0;
            id_q   <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
        end else if (capture) begin
            op_a_q <= req_a[grant_idx*WIDTH +: WIDTH];
            op_b_q <= req_b[grant_idx*WIDTH +: WIDTH];
            id_q   <= grant_idx;
            ptr_q  <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    generate
        if (LATENCY == 0) begin : g_add_comb
            assign sum = op_a_q + op_b_q;
        end else begin : g_add_reg
            logic [WIDTH-1:0] sum_q;
            always_ff @(posedge aclk or negedge arstn) begin
                if (!arstn) begin
                    sum_q <= '0;
                end else if (srst) begin
                    sum_q <= '0;
                end else begin
                    sum_q <= op_a_q + op_b_q;
                end
            end
            assign sum = sum_q;
        end
    endgenerate

    assign rsp_c  = sum;
    assign rsp_id = id_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - randomized and directed bench for adder_arbiter
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 1;
    localparam int IDW   = 2;

    logic                  aclk = 1'b0;
    logic                  arstn;
    logic                  srst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WIDTH-1:0]      rsp_c;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    logic [NREQ-1:0]       req_valid_z;
    logic [NREQ-1:0]       req_ready_z;
    logic [NREQ*WIDTH-1:0] req_a_z;
    logic [NREQ*WIDTH-1:0] req_b_z;
    logic                  rsp_valid_z;
    logic                  rsp_ready_z;
    logic [WIDTH-1:0]      rsp_c_z;
    logic [IDW-1:0]        rsp_id_z;
    logic                  busy_z;

    always #5 aclk = ~aclk;

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(1)) u_dut (
        .aclk(aclk), .arstn(arstn), .srst(srst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_id(rsp_id),
        .busy(busy)
    );

    adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(0)) u_dut_z (
        .aclk(aclk), .arstn(arstn), .srst(srst),
        .req_valid(req_valid_z), .req_ready(req_ready_z), .req_a(req_a_z), .req_b(req_b_z),
        .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z), .rsp_c(rsp_c_z), .rsp_id(rsp_id_z),
        .busy(busy_z)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Transaction-level reference: pointer, one in-flight op, cycles left until its response.
    int               m_ptr;
    bit               m_inflight;
    int               m_left;
    logic [WIDTH-1:0] m_c;
    int               m_id;

    int               dut_g[$];
    logic [WIDTH-1:0] dut_c[$];
    int               dut_id[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int model_grant(input logic [NREQ-1:0] v);
        for (int k = 0; k < NREQ; k++)
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 0; m_inflight = 0; m_left = 0; m_c = '0; m_id = 0;
    endtask

    task automatic set_op(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
    endtask

    task automatic clear_logs();
        dut_g.delete(); dut_c.delete(); dut_id.delete();
    endtask

    // One clock cycle: check outputs against the model, log DUT activity, advance the model.
    task automatic step();
        int g;
        logic [NREQ-1:0] exp_rdy;
        bit exp_rv;
        #1;
        g = (!m_inflight && !srst) ? model_grant(req_valid) : -1;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        exp_rv = m_inflight && (m_left == 0);
        check("req_ready", req_ready, exp_rdy);
        check("busy", busy, m_inflight);
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_c", rsp_c, m_c);
            check("rsp_id", rsp_id, m_id);
        end
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_g.push_back(i);
        if (rsp_valid && rsp_ready) begin
            dut_c.push_back(rsp_c);
            dut_id.push_back(int'(rsp_id));
        end
        @(posedge aclk);
        if (srst) begin
            model_reset();
        end else if (g >= 0) begin
            m_c        = req_a[g*WIDTH +: WIDTH] + req_b[g*WIDTH +: WIDTH];
            m_id       = g;
            m_ptr      = (g + 1) % NREQ;
            m_inflight = 1;
            m_left     = LAT;
        end else if (m_inflight && m_left > 0) begin
            m_left--;
        end else if (m_inflight && rsp_ready) begin
            m_inflight = 0;
        end
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int cnt;
        arstn = 1'b0; srst = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        req_valid_z = '0; req_a_z = '0; req_b_z = '0; rsp_ready_z = 1'b1;
        model_reset();
        #3;
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_rsp_c", rsp_c, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_req_ready", req_ready, 0);
        @(negedge aclk);
        arstn = 1'b1;

        // srst in IDLE with a pending request: no grant
        req_valid = 4'b0110; srst = 1'b1;
        step();
        srst = 1'b0; req_valid = '0;

        // single request
        clear_logs();
        req_valid = 4'b0001; set_op(0, 5, 7);
        step();
        req_valid = '0;
        steps(3);
        check("t1_rsp_cnt", dut_c.size(), 1);
        check("t1_rsp_c", dut_c[0], 12);
        check("t1_rsp_id", dut_id[0], 0);
        check("t1_grant", dut_g[0], 0);

        // wrap-around arithmetic
        clear_logs();
        req_valid = 4'b0100; set_op(2, 32'hFFFF_FFFF, 32'h1);
        step();
        req_valid = '0; steps(3);
        req_valid = 4'b0100; set_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        req_valid = '0; steps(3);
        check("t2_rsp_cnt", dut_c.size(), 2);
        check("t2_wrap0", dut_c[0], 0);
        check("t2_id", dut_id[0], 2);
        check("t2_wrap1", dut_c[1], 32'hFFFF_FFFE);

        // fairness
        srst = 1'b1; step(); srst = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, WIDTH'(i), 100);
        clear_logs();
        req_valid = 4'b1111; rsp_ready = 1'b1;
        steps(18);
        check("t3_grant_cnt", dut_g.size(), 6);
        for (int i = 0; i < 6; i++) check($sformatf("t3_grant%0d", i), dut_g[i], i % NREQ);
        for (int i = 0; i < 4; i++) check($sformatf("t3_rsp%0d", i), dut_c[i], 100 + i);
        srst = 1'b1; req_valid = '0; step(); srst = 1'b0;
        clear_logs();
        req_valid = 4'b1111; step();
        req_valid = 4'b1001; steps(6);
        check("t3b_cnt", dut_g.size(), 3);
        check("t3b_g0", dut_g[0], 0);
        check("t3b_g1", dut_g[1], 3);
        check("t3b_g2", dut_g[2], 0);

        // backpressure
        req_valid = '0; steps(3);
        clear_logs();
        req_valid = 4'b0010; set_op(1, 32'h1234_0000, 32'h0000_5678); rsp_ready = 1'b0;
        step();
        req_valid = 4'b1111;
        steps(12);
        rsp_ready = 1'b1;
        step();
        step();
        check("t4_rsp", dut_c[0], 32'h1234_5678);
        check("t4_grants", dut_g.size(), 2);
        check("t4_next", dut_g[1], 2);

        // srst during EXEC drops the op and restarts the search at 0
        req_valid = '0; steps(3);
        clear_logs();
        req_valid = 4'b0100; step();
        req_valid = '0; srst = 1'b1; step();
        srst = 1'b0; req_valid = 4'b1111; step();
        req_valid = '0; steps(3);
        check("t5_grant", dut_g[1], 0);
        check("t5_rsp_cnt", dut_c.size(), 1);

        // arstn asserted asynchronously in RESP
        req_valid = 4'b0001; step();
        req_valid = '0; rsp_ready = 1'b0; step();
        #2 arstn = 1'b0;
        #1;
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_busy", busy, 0);
        check("t6_rsp_c", rsp_c, 0);
        model_reset();
        @(negedge aclk);
        arstn = 1'b1;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++)
                set_op(i, ($urandom % 8 == 0) ? 32'hFFFF_FFFF : $urandom, $urandom);
            rsp_ready = ($urandom % 4) != 0;
            srst      = ($urandom % 40) == 0;
            step();
        end
        srst = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        steps(3);

        // LATENCY=0 instance
        req_valid_z = 4'b0001; req_a_z[0 +: WIDTH] = 5; req_b_z[0 +: WIDTH] = 7;
        #1;
        check("z_ready", req_ready_z, 4'b0001);
        @(posedge aclk); #1;
        req_valid_z = '0;
        check("z_rsp_valid", rsp_valid_z, 1);
        check("z_rsp_c", rsp_c_z, 12);
        check("z_rsp_id", rsp_id_z, 0);
        check("z_ready_resp", req_ready_z, 0);
        @(posedge aclk); #1;
        check("z_idle", busy_z, 0);
        for (int i = 0; i < NREQ; i++) begin
            req_a_z[i*WIDTH +: WIDTH] = WIDTH'(i);
            req_b_z[i*WIDTH +: WIDTH] = 100;
        end
        req_valid_z = 4'b1111;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (|req_ready_z) cnt++;
            @(posedge aclk); #1;
        end
        check("z_b2b_grants", cnt, 4);
        req_valid_z = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_arbiter.md
Name: adder_arbiter

Overview:
- Shares one adder instance (same LATENCY/WIDTH parameters) between NREQ requesters.
- Round-robin arbitration; one operation in flight at a time; valid/ready handshake on both sides.
- Sits between requesting engines and the shared add datapath; returns the sum tagged with the requester index.

Parameters:
- NREQ, 4, number of requesters (2..16).
- WIDTH, 32, operand/result width.
- LATENCY, 1, latency of the instanced adder; 0 = combinational, 1 = registered; other values illegal.
- IDW, derived, max(1, clog2(NREQ)), width of the requester id.

Ports:
- aclk  in  1  clock.
- arstn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous active-high reset; also drives the adder srst.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; at most one bit high per cycle.
- req_a  in  NREQ*WIDTH  operand a; requester i uses slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same slicing as req_a.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accept.
- rsp_c  out  WIDTH  sum, modulo 2^WIDTH.
- rsp_id  out  IDW  index of the requester that owns rsp_c.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (arstn low, or srst high at a clock edge): FSM=IDLE, ptr=0, operand/id regs=0, rsp_valid=0, rsp_id=0, rsp_c=0, busy=0.
- req_ready is forced to 0 while srst=1.
- FSM states: IDLE, EXEC, RESP. EXEC is used only when LATENCY=1.
- IDLE, grant selection:
  - Search for the first set req_valid bit starting at index ptr, ascending, wrapping NREQ-1 -> 0; the result is g.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
- IDLE, capture edge:
  - Capture req_a[g], req_b[g] into the operand registers and g into the id register.
  - ptr <= (g+1) mod NREQ.
  - Next state is EXEC if LATENCY=1, otherwise RESP.
- IDLE with no req_valid set: stay in IDLE; ptr unchanged.
- Adder inputs are the operand registers, which stay stable from capture until the response is accepted.
- EXEC: one cycle, then RESP; req_ready all 0.
- RESP:
  - rsp_valid=1.
  - rsp_c = adder output, rsp_id = id register; both stable while rsp_valid=1.
  - On rsp_valid & rsp_ready: next state IDLE, rsp_valid drops the next cycle.
  - rsp_ready low: hold indefinitely; no new grant is issued.
- Latency from the req_valid & req_ready edge to rsp_valid high: 1 cycle (LATENCY=0) or 2 cycles (LATENCY=1).
- Throughput, with rsp_ready tied high: one operation per 2 cycles (LATENCY=0) or per 3 cycles (LATENCY=1).
- Requester obligations: a requester holds req_valid and its operands until it sees req_ready; req_valid may drop without penalty before a grant.
- Arithmetic: no carry out; overflow wraps modulo 2^WIDTH.
- srst or arstn during EXEC/RESP: the in-flight operation is discarded with no response, and ptr returns to 0.
- srst high in IDLE with req_valid set: no grant, no capture.
- Fairness: under continuous requests from all NREQ requesters, each is granted exactly once per NREQ grants.

Test Plan:
- Single request, LATENCY=1: req_valid=0001, a=5, b=7 -> req_ready[0] high for 1 cycle; rsp_valid 2 cycles later with rsp_c=12, rsp_id=0; busy high from capture until accept.
- Wrap-around arithmetic: requester 2 sends a=32'hFFFFFFFF, b=1 -> rsp_c=0, rsp_id=2; a=32'hFFFFFFFF, b=32'hFFFFFFFF -> rsp_c=32'hFFFFFFFE.
- Fairness: req_valid=1111 held, rsp_ready=1, operands a=i, b=100 -> grant order 0,1,2,3,0,1; rsp_c sequence 100,101,102,103,100,...; then req_valid=1001 after grant to 0 -> next grant 3, then 0.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_c, rsp_id stable; req_ready stays 0; on rsp_ready=1, the next grant occurs in the cycle after rsp_valid drops.
- Reset mid-op: srst pulsed during EXEC -> no rsp_valid, FSM IDLE, next grant starts search at index 0; repeat with arstn asserted asynchronously in RESP -> rsp_valid falls immediately.
- LATENCY=0 build: same single-request stimulus -> rsp_valid 1 cycle after grant, rsp_c=12; back-to-back requests accepted every 2 cycles.
